iod_dly_tap_ctrl: RTL and testbench

- Per-lane sequencer for the PF IOD dynamic delay line and eye monitor, in the DDR4 PHY training path.
- Accepts single commands from the training engine (LOAD, INC n, DEC n, SAMPLE).
- Drives DELAY_LINE_LOAD/MOVE/DIRECTION and EYE_MONITOR_CLEAR_FLAGS with correct spacing.
- Tracks the current tap and returns one response per command with eye-monitor and out-of-range status.

---
 rtl/iod_dly_pkg.sv | 40 ++++
 rtl/iod_dly_timer.sv | 37 +++
 rtl/iod_dly_tap_ctrl.sv | 277 +++++++++++++++++++++++++++
 tb/tb_iod_dly_tap_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iod_dly_pkg.sv
// Shared definitions for the IOD delay-line tap sequencer.
// Holds the command opcodes, the sequencer state encoding, the default
// timing constants and the interval-timer width.
package iod_dly_pkg;

    typedef enum logic [1:0] {
        OP_LOAD   = 2'b00,
        OP_INC    = 2'b01,
        OP_DEC    = 2'b10,
        OP_SAMPLE = 2'b11
    } op_e;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_LOAD   = 4'd1,
        ST_DIR    = 4'd2,
        ST_MOVE   = 4'd3,
        ST_GAP    = 4'd4,
        ST_SETTLE = 4'd5,
        ST_CLEAR  = 4'd6,
        ST_SAMPLE = 4'd7,
        ST_RESP   = 4'd8
    } state_e;

    localparam int DEF_TAP_W         = 8;
    localparam int DEF_TAP_MAX       = 255;
    localparam int DEF_LOAD_TAP      = 1;
    localparam int DEF_MOVE_GAP      = 4;
    localparam int DEF_SETTLE_CYCLES = 8;
    localparam int DEF_SAMPLE_CYCLES = 16;

    // Wide enough for any GAP/SETTLE/SAMPLE interval minus one.
    localparam int TMR_W = 16;

    // INC and DEC are the only commands that step the delay line.
    function automatic logic is_move_op(input op_e op);
        return (op == OP_INC) || (op == OP_DEC);
    endfunction

endpackage

// File: rtl/iod_dly_timer.sv
// Loadable down-counter used for the GAP, SETTLE and SAMPLE intervals.
// Ports:
//   clk      - fabric clock
//   rst      - synchronous reset, active-high
//   load     - load load_val this cycle (wins over counting)
//   load_val - interval length minus one
//   done     - counter is at zero (last cycle of the interval)
module iod_dly_timer
    import iod_dly_pkg::*;
#(
    parameter int W = TMR_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] count_r;

    // Count down to zero and hold there until reloaded.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {W{1'b0}};
        end else if (load) begin
            count_r <= load_val;
        end else if (count_r != {W{1'b0}}) begin
            count_r <= count_r - {{(W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign done = (count_r == {W{1'b0}});

endmodule

// File: rtl/iod_dly_tap_ctrl.sv
// Per-lane sequencer for the IOD dynamic delay line and eye monitor.
// Accepts one LOAD / INC n / DEC n / SAMPLE command at a time, drives the
// IOD strobes with the required spacing, tracks the tap and returns one
// response per command.
// Ports:
//   FAB_CLK, SYNC_RST              - clock, synchronous active-high reset
//   CMD_VALID/READY/OP/COUNT       - command handshake from training engine
//   DELAY_LINE_LOAD/MOVE/DIRECTION - delay-line strobes to the IOD
//   DELAY_LINE_OUT_OF_RANGE        - IOD range flag
//   EYE_MONITOR_CLEAR_FLAGS        - eye-monitor flag clear to the IOD
//   EYE_MONITOR_EARLY/LATE         - eye-monitor flags from the IOD
//   RSP_VALID/EARLY/LATE/OOR       - one-cycle response
//   TAP_VALUE, TAP_VALID, BUSY     - tap tracking and status
module iod_dly_tap_ctrl
    import iod_dly_pkg::*;
#(
    parameter int TAP_W         = DEF_TAP_W,
    parameter int TAP_MAX       = DEF_TAP_MAX,
    parameter int LOAD_TAP      = DEF_LOAD_TAP,
    parameter int MOVE_GAP      = DEF_MOVE_GAP,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int SAMPLE_CYCLES = DEF_SAMPLE_CYCLES
) (
    input  logic             FAB_CLK,
    input  logic             SYNC_RST,
    input  logic             CMD_VALID,
    output logic             CMD_READY,
    input  logic [1:0]       CMD_OP,
    input  logic [TAP_W-1:0] CMD_COUNT,
    output logic             DELAY_LINE_LOAD,
    output logic             DELAY_LINE_MOVE,
    output logic             DELAY_LINE_DIRECTION,
    input  logic             DELAY_LINE_OUT_OF_RANGE,
    output logic             EYE_MONITOR_CLEAR_FLAGS,
    input  logic             EYE_MONITOR_EARLY,
    input  logic             EYE_MONITOR_LATE,
    output logic             RSP_VALID,
    output logic             RSP_EARLY,
    output logic             RSP_LATE,
    output logic             RSP_OOR,
    output logic [TAP_W-1:0] TAP_VALUE,
    output logic             TAP_VALID,
    output logic             BUSY
);

    localparam logic [TAP_W-1:0] ONE_TAP     = TAP_W'(1);
    localparam logic [TAP_W-1:0] ZERO_TAP    = {TAP_W{1'b0}};
    localparam logic [TAP_W-1:0] MAX_TAP     = TAP_W'(TAP_MAX);
    localparam logic [TMR_W-1:0] SETTLE_LEN  = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] SAMPLE_LEN  = TMR_W'(SAMPLE_CYCLES - 1);
    // A MOVE pulse plus (MOVE_GAP-1) gap cycles gives the pulse spacing.
    localparam logic [TMR_W-1:0] GAP_LEN     = TMR_W'(MOVE_GAP - 2);

    state_e           state_r;
    op_e              op_r;
    logic [TAP_W-1:0] rem_r;
    logic             oor_r;
    logic             acc_early_r;
    logic             acc_late_r;

    logic             oor_now_s;
    logic             step_ok_s;
    logic [TAP_W-1:0] tap_step_s;
    logic             tmr_load_s;
    logic [TMR_W-1:0] tmr_val_s;
    logic             tmr_done_s;

    // Range status and next-tap arithmetic for the pending MOVE decision.
    always_comb begin
        oor_now_s = oor_r | (is_move_op(op_r) & DELAY_LINE_OUT_OF_RANGE);
        if (DELAY_LINE_DIRECTION) begin
            step_ok_s  = !oor_now_s && (TAP_VALUE != MAX_TAP);
            tap_step_s = TAP_VALUE + ONE_TAP;
        end else begin
            step_ok_s  = !oor_now_s && (TAP_VALUE != ZERO_TAP);
            tap_step_s = TAP_VALUE - ONE_TAP;
        end
    end

    // Arm the interval timer on every transition into GAP, SETTLE or SAMPLE.
    always_comb begin
        tmr_load_s = 1'b0;
        tmr_val_s  = SETTLE_LEN;
        case (state_r)
            ST_LOAD, ST_CLEAR: begin
                tmr_load_s = 1'b1;
            end
            ST_DIR: begin
                tmr_load_s = !step_ok_s;
            end
            ST_MOVE: begin
                tmr_load_s = 1'b1;
                if ((rem_r == ZERO_TAP) || oor_now_s) begin
                    tmr_val_s = SETTLE_LEN;
                end else begin
                    tmr_val_s = GAP_LEN;
                end
            end
            ST_GAP: begin
                tmr_load_s = !step_ok_s && (tmr_done_s || oor_now_s);
            end
            ST_SETTLE: begin
                if (tmr_done_s && (op_r == OP_SAMPLE)) begin
                    tmr_load_s = 1'b1;
                    tmr_val_s  = SAMPLE_LEN;
                end else begin
                    tmr_load_s = 1'b0;
                end
            end
            default: begin
                tmr_load_s = 1'b0;
            end
        endcase
    end

    iod_dly_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk      (FAB_CLK),
        .rst      (SYNC_RST),
        .load     (tmr_load_s),
        .load_val (tmr_val_s),
        .done     (tmr_done_s)
    );

    // Command sequencer with registered strobes and response.
    always_ff @(posedge FAB_CLK) begin
        if (SYNC_RST) begin
            state_r                 <= ST_IDLE;
            op_r                    <= OP_LOAD;
            rem_r                   <= ZERO_TAP;
            oor_r                   <= 1'b0;
            acc_early_r             <= 1'b0;
            acc_late_r              <= 1'b0;
            CMD_READY               <= 1'b1;
            DELAY_LINE_LOAD         <= 1'b0;
            DELAY_LINE_MOVE         <= 1'b0;
            DELAY_LINE_DIRECTION    <= 1'b0;
            EYE_MONITOR_CLEAR_FLAGS <= 1'b0;
            RSP_VALID               <= 1'b0;
            RSP_EARLY               <= 1'b0;
            RSP_LATE                <= 1'b0;
            RSP_OOR                 <= 1'b0;
            TAP_VALUE               <= TAP_W'(LOAD_TAP);
            TAP_VALID               <= 1'b0;
            BUSY                    <= 1'b0;
        end else begin
            DELAY_LINE_LOAD         <= 1'b0;
            DELAY_LINE_MOVE         <= 1'b0;
            EYE_MONITOR_CLEAR_FLAGS <= 1'b0;
            RSP_VALID               <= 1'b0;
            RSP_EARLY               <= 1'b0;
            RSP_LATE                <= 1'b0;
            RSP_OOR                 <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (CMD_VALID) begin
                        op_r        <= op_e'(CMD_OP);
                        rem_r       <= CMD_COUNT;
                        oor_r       <= 1'b0;
                        acc_early_r <= 1'b0;
                        acc_late_r  <= 1'b0;
                        CMD_READY   <= 1'b0;
                        BUSY        <= 1'b1;
                        case (op_e'(CMD_OP))
                            OP_LOAD: begin
                                state_r         <= ST_LOAD;
                                DELAY_LINE_LOAD <= 1'b1;
                                TAP_VALUE       <= TAP_W'(LOAD_TAP);
                            end
                            OP_INC, OP_DEC: begin
                                if (CMD_COUNT == ZERO_TAP) begin
                                    // Zero-step move answers immediately.
                                    state_r   <= ST_RESP;
                                    RSP_VALID <= 1'b1;
                                end else begin
                                    state_r              <= ST_DIR;
                                    DELAY_LINE_DIRECTION <= (op_e'(CMD_OP) == OP_INC);
                                end
                            end
                            OP_SAMPLE: begin
                                state_r                 <= ST_CLEAR;
                                EYE_MONITOR_CLEAR_FLAGS <= 1'b1;
                            end
                            default: begin
                                state_r <= ST_IDLE;
                            end
                        endcase
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_LOAD, ST_CLEAR: begin
                    state_r <= ST_SETTLE;
                end
                ST_DIR: begin
                    if (step_ok_s) begin
                        state_r         <= ST_MOVE;
                        DELAY_LINE_MOVE <= 1'b1;
                        TAP_VALUE       <= tap_step_s;
                        rem_r           <= rem_r - ONE_TAP;
                    end else begin
                        state_r <= ST_SETTLE;
                        oor_r   <= 1'b1;
                    end
                end
                ST_MOVE: begin
                    oor_r <= oor_now_s;
                    if ((rem_r == ZERO_TAP) || oor_now_s) begin
                        state_r <= ST_SETTLE;
                    end else begin
                        state_r <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    // An IOD range flag cuts the gap short; a bound hit is
                    // only acted on in the slot where the pulse would occur.
                    if (!step_ok_s && (tmr_done_s || oor_now_s)) begin
                        state_r <= ST_SETTLE;
                        oor_r   <= 1'b1;
                    end else if (tmr_done_s) begin
                        state_r         <= ST_MOVE;
                        DELAY_LINE_MOVE <= 1'b1;
                        TAP_VALUE       <= tap_step_s;
                        rem_r           <= rem_r - ONE_TAP;
                    end else begin
                        state_r <= ST_GAP;
                    end
                end
                ST_SETTLE: begin
                    oor_r <= oor_now_s;
                    if (tmr_done_s) begin
                        if (op_r == OP_SAMPLE) begin
                            state_r <= ST_SAMPLE;
                        end else begin
                            state_r   <= ST_RESP;
                            RSP_VALID <= 1'b1;
                            RSP_OOR   <= oor_now_s;
                            if (op_r == OP_LOAD) begin
                                TAP_VALID <= 1'b1;
                            end else begin
                                TAP_VALID <= TAP_VALID;
                            end
                        end
                    end else begin
                        state_r <= ST_SETTLE;
                    end
                end
                ST_SAMPLE: begin
                    acc_early_r <= acc_early_r | EYE_MONITOR_EARLY;
                    acc_late_r  <= acc_late_r | EYE_MONITOR_LATE;
                    if (tmr_done_s) begin
                        state_r   <= ST_RESP;
                        RSP_VALID <= 1'b1;
                        RSP_EARLY <= acc_early_r | EYE_MONITOR_EARLY;
                        RSP_LATE  <= acc_late_r | EYE_MONITOR_LATE;
                    end else begin
                        state_r <= ST_SAMPLE;
                    end
                end
                ST_RESP: begin
                    state_r              <= ST_IDLE;
                    CMD_READY            <= 1'b1;
                    BUSY                 <= 1'b0;
                    DELAY_LINE_DIRECTION <= 1'b0;
                end
                default: begin
                    state_r              <= ST_IDLE;
                    CMD_READY            <= 1'b1;
                    BUSY                 <= 1'b0;
                    DELAY_LINE_DIRECTION <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iod_dly_tap_ctrl.sv
// Scoreboard bench for iod_dly_tap_ctrl: each issued command pushes its
// expected response (from a tap/interval model) and a negedge monitor
// pops and compares whenever RSP_VALID is seen.
module tb_iod_dly_tap_ctrl;
    import iod_dly_pkg::*;

    localparam int S    = 8;
    localparam int W    = 16;
    localparam int G    = 4;
    localparam int LT   = 1;
    localparam int TMAX = 255;

    logic       FAB_CLK = 1'b0;
    logic       SYNC_RST = 1'b1;
    logic       CMD_VALID = 1'b0;
    logic       CMD_READY;
    logic [1:0] CMD_OP = 2'b00;
    logic [7:0] CMD_COUNT = 8'd0;
    logic       DELAY_LINE_LOAD, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION;
    logic       DELAY_LINE_OUT_OF_RANGE = 1'b0;
    logic       EYE_MONITOR_CLEAR_FLAGS;
    logic       EYE_MONITOR_EARLY = 1'b0;
    logic       EYE_MONITOR_LATE = 1'b0;
    logic       RSP_VALID, RSP_EARLY, RSP_LATE, RSP_OOR;
    logic [7:0] TAP_VALUE;
    logic       TAP_VALID, BUSY;

    iod_dly_tap_ctrl dut (
        .FAB_CLK                 (FAB_CLK),
        .SYNC_RST                (SYNC_RST),
        .CMD_VALID               (CMD_VALID),
        .CMD_READY               (CMD_READY),
        .CMD_OP                  (CMD_OP),
        .CMD_COUNT               (CMD_COUNT),
        .DELAY_LINE_LOAD         (DELAY_LINE_LOAD),
        .DELAY_LINE_MOVE         (DELAY_LINE_MOVE),
        .DELAY_LINE_DIRECTION    (DELAY_LINE_DIRECTION),
        .DELAY_LINE_OUT_OF_RANGE (DELAY_LINE_OUT_OF_RANGE),
        .EYE_MONITOR_CLEAR_FLAGS (EYE_MONITOR_CLEAR_FLAGS),
        .EYE_MONITOR_EARLY       (EYE_MONITOR_EARLY),
        .EYE_MONITOR_LATE        (EYE_MONITOR_LATE),
        .RSP_VALID               (RSP_VALID),
        .RSP_EARLY               (RSP_EARLY),
        .RSP_LATE                (RSP_LATE),
        .RSP_OOR                 (RSP_OOR),
        .TAP_VALUE               (TAP_VALUE),
        .TAP_VALID               (TAP_VALID),
        .BUSY                    (BUSY)
    );

    always #5 FAB_CLK = ~FAB_CLK;

    int cyc = 0;
    always @(posedge FAB_CLK) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int t0;
        int rsp_lat;
        int chk_time;
        int early;
        int late;
        int oor;
        int tap;
        int tvalid;
        int moves;
        int dir;
        int loads;
        int clears;
    } exp_t;

    exp_t sb_q[$];
    int   m_tap   = LT;
    int   m_valid = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pulse bookkeeping every cycle, scoreboard compare on RSP_VALID.
    int n_mv = 0, n_ld = 0, n_clr = 0;
    int mv_first = -1, mv_last = -1, ld_cyc = -1, clr_cyc = -1;
    always @(negedge FAB_CLK) begin : monitor
        exp_t e;
        if (SYNC_RST) begin
            n_mv = 0; n_ld = 0; n_clr = 0;
            mv_first = -1; mv_last = -1; ld_cyc = -1; clr_cyc = -1;
        end else begin
            if (DELAY_LINE_LOAD || DELAY_LINE_MOVE || EYE_MONITOR_CLEAR_FLAGS)
                chk("pulse_exclusive", int'(DELAY_LINE_LOAD) + int'(DELAY_LINE_MOVE)
                    + int'(EYE_MONITOR_CLEAR_FLAGS), 1);
            if (DELAY_LINE_MOVE) begin
                n_mv++;
                if (mv_first < 0) mv_first = cyc;
                mv_last = cyc;
                if (sb_q.size() == 0) chk("move_without_cmd", 1, 0);
                else chk("move_direction", int'(DELAY_LINE_DIRECTION), sb_q[0].dir);
            end
            if (DELAY_LINE_LOAD) begin n_ld++; ld_cyc = cyc; end
            if (EYE_MONITOR_CLEAR_FLAGS) begin n_clr++; clr_cyc = cyc; end
            if (RSP_VALID) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_rsp", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    if (e.chk_time != 0) chk("rsp_latency", cyc - e.t0, e.rsp_lat);
                    chk("rsp_early", int'(RSP_EARLY), e.early);
                    chk("rsp_late", int'(RSP_LATE), e.late);
                    chk("rsp_oor", int'(RSP_OOR), e.oor);
                    chk("tap_value", int'(TAP_VALUE), e.tap);
                    chk("tap_valid", int'(TAP_VALID), e.tvalid);
                    chk("rsp_busy", int'(BUSY), 1);
                    chk("rsp_ready", int'(CMD_READY), 0);
                    chk("move_count", n_mv, e.moves);
                    chk("load_count", n_ld, e.loads);
                    chk("clear_count", n_clr, e.clears);
                    if (e.chk_time != 0 && e.moves > 0) begin
                        chk("move_first_cyc", mv_first - e.t0, 2);
                        chk("move_last_cyc", mv_last - e.t0, 2 + (e.moves - 1) * G);
                    end
                    if (e.loads > 0) chk("load_cyc", ld_cyc - e.t0, 1);
                    if (e.clears > 0) chk("clear_cyc", clr_cyc - e.t0, 1);
                end
                n_mv = 0; n_ld = 0; n_clr = 0;
                mv_first = -1; mv_last = -1; ld_cyc = -1; clr_cyc = -1;
            end
        end
    end

    // Issue one command, push its expected response, then play out the
    // EARLY/LATE/OOR stimulus until the response appears.
    // mode: 0 random eye flags, 1 directed sample, 2 IOD range flag after 2nd pulse
    task automatic run_cmd(input logic [1:0] op, input int n, input int mode);
        bit   ea[64];
        bit   la[64];
        exp_t e;
        int   avail, steps, r, moves;
        bit   got, done;
        @(posedge FAB_CLK); #1;
        CMD_VALID = 1'b1;
        CMD_OP    = op;
        CMD_COUNT = 8'(n);
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge FAB_CLK);
            if (CMD_READY) got = 1'b1;
        end
        if (!got) begin
            chk("ready_timeout", 0, 1);
            CMD_VALID = 1'b0;
            return;
        end
        for (int i = 0; i < 64; i++) begin
            if (mode == 1) begin
                ea[i] = 1'b0;
                la[i] = 1'b0;
            end else begin
                ea[i] = ($urandom_range(0, 11) == 0);
                la[i] = ($urandom_range(0, 11) == 0);
            end
        end
        if (mode == 1) begin
            ea[2 + S + 5] = 1'b1;
            la[3] = 1'b1; la[4] = 1'b1; la[5] = 1'b1;
        end
        e = '{t0: cyc, rsp_lat: 0, chk_time: (mode != 2), early: 0, late: 0, oor: 0,
              tap: 0, tvalid: 0, moves: 0, dir: (op == OP_INC), loads: 0, clears: 0};
        if (op == OP_LOAD) begin
            m_tap = LT; m_valid = 1; e.loads = 1; e.rsp_lat = 2 + S;
        end else if (op == OP_SAMPLE) begin
            e.clears = 1; e.rsp_lat = 2 + S + W;
            for (int k = 2 + S; k <= 1 + S + W; k++) begin
                if (ea[k]) e.early = 1;
                if (la[k]) e.late = 1;
            end
        end else if (n == 0) begin
            e.rsp_lat = 1;
        end else begin
            avail = (op == OP_INC) ? (TMAX - m_tap) : m_tap;
            steps = (n < avail) ? n : avail;
            if (mode == 2) steps = 2;
            e.oor = (steps < n) ? 1 : 0;
            e.moves = steps;
            m_tap = (op == OP_INC) ? m_tap + steps : m_tap - steps;
            e.rsp_lat = (steps == n) ? 3 + (n - 1) * G + S : 2 + steps * G + S;
        end
        e.tap = m_tap;
        e.tvalid = m_valid;
        sb_q.push_back(e);
        @(posedge FAB_CLK); #1;
        CMD_VALID = 1'b0;
        CMD_OP    = 2'($urandom);
        CMD_COUNT = 8'($urandom);
        r = 1; moves = 0; done = 1'b0;
        while (!done && r < 1500) begin
            EYE_MONITOR_EARLY       = (r < 64) ? ea[r] : 1'b0;
            EYE_MONITOR_LATE        = (r < 64) ? la[r] : 1'b0;
            DELAY_LINE_OUT_OF_RANGE = (mode == 2 && moves >= 2);
            @(negedge FAB_CLK);
            if (DELAY_LINE_MOVE) moves++;
            if (RSP_VALID) done = 1'b1;
            @(posedge FAB_CLK); #1;
            r++;
        end
        EYE_MONITOR_EARLY = 1'b0;
        EYE_MONITOR_LATE = 1'b0;
        DELAY_LINE_OUT_OF_RANGE = 1'b0;
        if (!done) chk("rsp_timeout", 0, 1);
        @(negedge FAB_CLK);
        chk("idle_ready", int'(CMD_READY), 1);
        chk("idle_direction", int'(DELAY_LINE_DIRECTION), 0);
        chk("idle_busy", int'(BUSY), 0);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_ready", int'(CMD_READY), 1);
        chk("rst_tap", int'(TAP_VALUE), LT);
        chk("rst_tap_valid", int'(TAP_VALID), 0);
        chk("rst_busy", int'(BUSY), 0);
        chk("rst_rsp_valid", int'(RSP_VALID), 0);
        chk("rst_rsp_flags", int'({RSP_EARLY, RSP_LATE, RSP_OOR}), 0);
        chk("rst_strobes", int'({DELAY_LINE_LOAD, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION,
                                 EYE_MONITOR_CLEAR_FLAGS}), 0);
    endtask

    initial begin : watchdog
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin : main
        exp_t er;
        int   mv;
        bit   got;
        SYNC_RST = 1'b1;
        repeat (3) @(posedge FAB_CLK);
        #1 SYNC_RST = 1'b0;
        @(negedge FAB_CLK);
        chk_reset_outputs();

        run_cmd(OP_LOAD, 0, 0);
        run_cmd(OP_INC, 3, 0);
        run_cmd(OP_DEC, 0, 0);
        run_cmd(OP_LOAD, 0, 0);
        run_cmd(OP_DEC, 5, 0);
        run_cmd(OP_LOAD, 0, 0);
        run_cmd(OP_INC, 254, 0);
        run_cmd(OP_INC, 1, 0);
        run_cmd(OP_DEC, 2, 0);
        run_cmd(OP_LOAD, 0, 0);
        run_cmd(OP_INC, 4, 2);
        run_cmd(OP_SAMPLE, 0, 1);

        repeat (40) begin
            run_cmd(2'($urandom_range(0, 3)),
                    ($urandom_range(0, 7) == 0) ? $urandom_range(0, 40) : $urandom_range(0, 6), 0);
        end

        // Reset in the middle of INC 8, after the third pulse.
        run_cmd(OP_LOAD, 0, 0);
        @(posedge FAB_CLK); #1;
        CMD_VALID = 1'b1; CMD_OP = OP_INC; CMD_COUNT = 8'd8;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge FAB_CLK);
            if (CMD_READY) got = 1'b1;
        end
        chk("abort_accept", int'(got), 1);
        er = '{t0: cyc, rsp_lat: 0, chk_time: 0, early: 0, late: 0, oor: 0,
               tap: 0, tvalid: 0, moves: 0, dir: 1, loads: 0, clears: 0};
        sb_q.push_back(er);
        @(posedge FAB_CLK); #1;
        CMD_VALID = 1'b0;
        mv = 0;
        for (int i = 0; i < 100 && mv < 3; i++) begin
            @(negedge FAB_CLK);
            if (DELAY_LINE_MOVE) mv++;
        end
        chk("abort_pulses_seen", mv, 3);
        @(posedge FAB_CLK); #1;
        SYNC_RST = 1'b1;
        sb_q.delete();
        m_tap = LT;
        m_valid = 0;
        @(posedge FAB_CLK); #1;
        SYNC_RST = 1'b0;
        @(negedge FAB_CLK);
        chk_reset_outputs();
        repeat (40) @(negedge FAB_CLK);

        run_cmd(OP_INC, 2, 0);
        run_cmd(OP_LOAD, 0, 0);
        run_cmd(OP_SAMPLE, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
